riscv_trap_ctrl: RTL

Trap-entry and trap-return sequencer between the exception/interrupt detect logic and the CSR file / IF stage. On an ecall, a machine-timer interrupt or an mret, it stalls and flushes the pipeline. It then drives the single CSR write port through a fixed sequence of writes (mepc, mcause, mstatus) and redirects fetch to the handler or return address. It is the only writer of trap CSRs; software CSR writes are blocked while it is busy.

---
 rtl/riscv_trap_ctrl_if.sv | 38 +++
 rtl/riscv_trap_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/riscv_trap_ctrl_if.sv
// Trap sequencer bus: request/context inputs from detect logic and CSR file,
// single CSR write port, pipeline control and fetch redirect handshake.
interface riscv_trap_ctrl_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int D_BUS_WIDTH = 64
);
  logic                   i_excep_req;
  logic                   i_irq_req;
  logic                   i_mret_req;
  logic [D_BUS_WIDTH-1:0] i_wb_pc;
  logic [D_BUS_WIDTH-1:0] i_irq_pc;
  logic [D_BUS_WIDTH-1:0] i_mtvec;
  logic [D_BUS_WIDTH-1:0] i_mepc;
  logic [D_BUS_WIDTH-1:0] i_mstatus;
  logic                   o_csr_we;
  logic [ADDR_WIDTH-1:0]  o_csr_waddr;
  logic [D_BUS_WIDTH-1:0] o_csr_wdata;
  logic                   o_stall;
  logic                   o_flush;
  logic                   o_redirect_vld;
  logic [D_BUS_WIDTH-1:0] o_redirect_pc;
  logic                   i_redirect_ack;
  logic                   o_busy;

  modport master (
    input  i_excep_req, i_irq_req, i_mret_req, i_wb_pc, i_irq_pc,
    input  i_mtvec, i_mepc, i_mstatus, i_redirect_ack,
    output o_csr_we, o_csr_waddr, o_csr_wdata, o_stall, o_flush,
    output o_redirect_vld, o_redirect_pc, o_busy
  );

  modport slave (
    output i_excep_req, i_irq_req, i_mret_req, i_wb_pc, i_irq_pc,
    output i_mtvec, i_mepc, i_mstatus, i_redirect_ack,
    input  o_csr_we, o_csr_waddr, o_csr_wdata, o_stall, o_flush,
    input  o_redirect_vld, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// Trap entry / mret sequencer: flush, write mepc/mcause/mstatus, redirect fetch.
// Latency: trap accept->IDLE 6 cycles, mret 4 cycles, with immediate redirect ack.
// Backpressure: REDIRECT holds vld/pc (and stall) until i_redirect_ack.
module riscv_trap_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int D_BUS_WIDTH = 64
) (
  input logic               i_clk,
  input logic               i_rst_n,
  riscv_trap_ctrl_if.master bus
);
  localparam int D = D_BUS_WIDTH;

  typedef enum logic [2:0] {
    IDLE, FLUSH, WR_MEPC, WR_MCAUSE, WR_MSTATUS, MRET_MSTATUS, REDIRECT
  } state_t;

  state_t         state, state_nxt;
  logic           cap_mret, cap_irq;
  logic [D-1:0]   cap_mepc, cap_mstatus, cap_target;
  logic           accept, take_irq, take_mret;
  logic [D-1:0]   vec_base, trap_target, mcause, ms_trap, ms_mret;

  // Gated by reset so every output reads 0 while reset is asserted.
  assign accept    = (state == IDLE) && i_rst_n &&
                     (bus.i_excep_req || bus.i_irq_req || bus.i_mret_req);
  assign take_irq  = !bus.i_excep_req && bus.i_irq_req;
  assign take_mret = !bus.i_excep_req && !bus.i_irq_req && bus.i_mret_req;

  assign vec_base    = {bus.i_mtvec[D-1:2], 2'b00};
  assign trap_target = (take_irq && bus.i_mtvec[1:0] == 2'b01) ?
                       vec_base + D'(28) : vec_base;

  assign mcause = cap_irq ? {1'b1, {(D-4){1'b0}}, 3'b111} : D'(11);

  always_comb begin
    ms_trap         = cap_mstatus;
    ms_trap[7]      = cap_mstatus[3];
    ms_trap[3]      = 1'b0;
    ms_trap[12:11]  = 2'b11;
    ms_mret         = cap_mstatus;
    ms_mret[3]      = cap_mstatus[7];
    ms_mret[7]      = 1'b1;
    ms_mret[12:11]  = 2'b11;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_mret    <= 1'b0;
      cap_irq     <= 1'b0;
      cap_mepc    <= '0;
      cap_mstatus <= '0;
      cap_target  <= '0;
    end else if (accept) begin
      cap_mret    <= take_mret;
      cap_irq     <= take_irq;
      cap_mepc    <= take_irq ? bus.i_irq_pc : bus.i_wb_pc;
      cap_mstatus <= bus.i_mstatus;
      cap_target  <= take_mret ? bus.i_mepc : trap_target;
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.o_csr_we       = 1'b0;
    bus.o_csr_waddr    = '0;
    bus.o_csr_wdata    = '0;
    bus.o_stall        = 1'b1;
    bus.o_flush        = 1'b0;
    bus.o_redirect_vld = 1'b0;
    bus.o_redirect_pc  = '0;
    case (state)
      IDLE: begin
        bus.o_stall = accept;
        if (accept) state_nxt = FLUSH;
      end
      FLUSH: begin
        bus.o_flush = 1'b1;
        state_nxt   = cap_mret ? MRET_MSTATUS : WR_MEPC;
      end
      WR_MEPC: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_WIDTH'(12'h341);
        bus.o_csr_wdata = cap_mepc;
        state_nxt       = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_WIDTH'(12'h342);
        bus.o_csr_wdata = mcause;
        state_nxt       = WR_MSTATUS;
      end
      WR_MSTATUS: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_WIDTH'(12'h300);
        bus.o_csr_wdata = ms_trap;
        state_nxt       = REDIRECT;
      end
      MRET_MSTATUS: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_WIDTH'(12'h300);
        bus.o_csr_wdata = ms_mret;
        state_nxt       = REDIRECT;
      end
      REDIRECT: begin
        bus.o_redirect_vld = 1'b1;
        bus.o_redirect_pc  = cap_target;
        if (bus.i_redirect_ack) state_nxt = IDLE;
      end
      default: begin
        bus.o_stall = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign bus.o_busy = (state != IDLE);
endmodule
